pwm_deadtime_monitor: RTL

PWM_DEADTIME_MONITOR -- requirements
Module: pwm_deadtime_monitor

---
 rtl/pwm_deadtime_monitor.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pwm_deadtime_monitor.sv
// rtl/pwm_deadtime_monitor.sv - measures duty, period and dead times of a complementary gate-drive pair
module pwm_deadtime_monitor #(
  parameter int W      = 10,
  parameter int MIN_DT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s,
  input  logic         nots,
  input  logic         clr_fault,
  output logic [W-1:0] duty,
  output logic [W-1:0] period,
  output logic [W-1:0] dt_fall,
  output logic [W-1:0] dt_rise,
  output logic         valid,
  output logic         overlap,
  output logic         dt_viol,
  output logic         stall
);

  localparam logic [W-1:0] MAX   = '1;
  localparam logic [W-1:0] MIN_V = W'(MIN_DT);

  typedef enum logic [2:0] {IDLE, HIGH, DT_FALL, LOW, DT_RISE} state_t;

  state_t       state_q, state_d;
  logic         s_m_q, s_y_q, s_p_q, n_m_q, n_y_q;
  logic [W-1:0] per_q, per_d, hi_q, hi_d, dtf_q, dtf_d, dtr_q, dtr_d;
  logic [W-1:0] duty_q, duty_d, period_q, period_d;
  logic [W-1:0] dt_fall_q, dt_fall_d, dt_rise_q, dt_rise_d;
  logic         valid_q, valid_d, overlap_q, overlap_d;
  logic         dt_viol_q, dt_viol_d, stall_q, stall_d;
  logic         s_rise;

  // Counters stick at all-ones so a runaway period never aliases to a short one.
  function automatic logic [W-1:0] inc(input logic [W-1:0] v);
    return (v == MAX) ? v : v + W'(1);
  endfunction

  assign s_rise  = s_y_q & ~s_p_q;
  assign duty    = duty_q;
  assign period  = period_q;
  assign dt_fall = dt_fall_q;
  assign dt_rise = dt_rise_q;
  assign valid   = valid_q;
  assign overlap = overlap_q;
  assign dt_viol = dt_viol_q;
  assign stall   = stall_q;

  // Two-flop synchronizers on both gate drives plus the delayed s copy for rise detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_m_q <= 1'b0;
      s_y_q <= 1'b0;
      s_p_q <= 1'b0;
      n_m_q <= 1'b0;
      n_y_q <= 1'b0;
    end else begin
      s_m_q <= s;
      s_y_q <= s_m_q;
      s_p_q <= s_y_q;
      n_m_q <= nots;
      n_y_q <= n_m_q;
    end
  end

  // Phase tracking, per-phase counting and result capture; counters follow the next state so each cycle lands in the phase it belongs to.
  always_comb begin
    state_d   = state_q;
    per_d     = per_q;
    hi_d      = hi_q;
    dtf_d     = dtf_q;
    dtr_d     = dtr_q;
    duty_d    = duty_q;
    period_d  = period_q;
    dt_fall_d = dt_fall_q;
    dt_rise_d = dt_rise_q;
    valid_d   = 1'b0;
    overlap_d = overlap_q & ~clr_fault;
    dt_viol_d = dt_viol_q & ~clr_fault;
    stall_d   = stall_q;

    case (state_q)
      HIGH:    if (!s_y_q) state_d = n_y_q ? LOW : DT_FALL;
      DT_FALL: if (n_y_q) state_d = LOW;
      LOW:     if (!n_y_q) state_d = DT_RISE;
      default: ;
    endcase

    if (state_q != IDLE) per_d = inc(per_q);
    if (state_d == HIGH)    hi_d  = inc(hi_q);
    if (state_d == DT_FALL) dtf_d = inc(dtf_q);
    if (state_d == DT_RISE) dtr_d = inc(dtr_q);

    if (s_y_q && n_y_q) begin
      overlap_d = 1'b1;
      state_d   = IDLE;
    end else if (state_q != IDLE && per_q == MAX) begin
      stall_d = 1'b1;
      state_d = IDLE;
    end else if (s_rise) begin
      // A rise from LOW is only reachable with nots already low, i.e. a zero-length rising dead time.
      if (state_q == LOW || state_q == DT_RISE) begin
        valid_d   = 1'b1;
        duty_d    = hi_q;
        period_d  = per_q;
        dt_fall_d = dtf_q;
        dt_rise_d = dtr_q;
        stall_d   = 1'b0;
        if (dtf_q < MIN_V || dtr_q < MIN_V) dt_viol_d = 1'b1;
      end
      state_d = HIGH;
      per_d   = W'(1);
      hi_d    = W'(1);
      dtf_d   = '0;
      dtr_d   = '0;
    end
  end

  // State, counters and reported results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      per_q     <= '0;
      hi_q      <= '0;
      dtf_q     <= '0;
      dtr_q     <= '0;
      duty_q    <= '0;
      period_q  <= '0;
      dt_fall_q <= '0;
      dt_rise_q <= '0;
      valid_q   <= 1'b0;
      overlap_q <= 1'b0;
      dt_viol_q <= 1'b0;
      stall_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      per_q     <= per_d;
      hi_q      <= hi_d;
      dtf_q     <= dtf_d;
      dtr_q     <= dtr_d;
      duty_q    <= duty_d;
      period_q  <= period_d;
      dt_fall_q <= dt_fall_d;
      dt_rise_q <= dt_rise_d;
      valid_q   <= valid_d;
      overlap_q <= overlap_d;
      dt_viol_q <= dt_viol_d;
      stall_q   <= stall_d;
    end
  end

endmodule
